mult_operand_seq: RTL and testbench

MULT_OPERAND_SEQ -- requirements
Module: mult_operand_seq

---
 rtl/mult_seq_pkg.sv | 22 ++
 rtl/key_debounce.sv | 97 +++++++++
 rtl/mult_operand_seq.sv | 165 ++++++++++++++++
 tb/tb_mult_operand_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared definitions for the multiplier operand sequencer:
//   OPW     - operand width presented to the multiplier
//   PW      - product width returned by the multiplier
//   state_t - sequencer state encoding (also exported on state_dbg)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package mult_seq_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [2:0] {
    EDIT_A = 3'd0,
    EDIT_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SHOW   = 3'd4
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Conditions one active-low pushbutton into single-cycle press events.
// The raw key is brought into the clk domain by a 2-flop synchronizer and
// then sampled only on the sampling tick. Two equal consecutive samples are
// needed to change the debounced state, so a one-sample glitch is ignored.
// The press event fires on the tick where the debounced state becomes pressed.
//
// Optional feature: AUTO_REPEAT_EN (macro). When defined and REPEAT_EN=1, a
// held key emits an extra event on every tick once REPEAT_TICKS ticks have
// passed since the press event. Without the macro no hold counter exists.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   key_n     in   raw asynchronous active-low key
//   tick      in   sampling clock enable (one clk cycle wide)
//   press_evt out  one-cycle press / repeat event
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module key_debounce #(
  parameter int REPEAT_TICKS = 4,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  input  logic tick,
  output logic press_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_last;      // previous tick sample (1 = high / not pressed)
  logic r_pressed;   // debounced state

  logic w_low;
  logic w_rise;
  logic w_repeat;

  assign w_low  = ~r_sync2;
  // Second consecutive low sample while still released.
  assign w_rise = tick & w_low & ~r_last & ~r_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_last    <= 1'b1;
      r_pressed <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      if (tick) begin
        r_last <= r_sync2;
        if (w_low && !r_last) begin
          r_pressed <= 1'b1;
        end else if (!w_low && r_last) begin
          r_pressed <= 1'b0;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  generate
    if (REPEAT_EN) begin : g_rep
      localparam int HW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
      // Ticks since the press event, saturating at REPEAT_TICKS.
      logic [HW-1:0] r_hold;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold <= '0;
        end else if (tick) begin
          if (w_rise) begin
            r_hold <= HW'(1);
          end else if (!r_pressed) begin
            r_hold <= '0;
          end else if (r_hold < HW'(REPEAT_TICKS)) begin
            r_hold <= r_hold + HW'(1);
          end
        end
      end

      assign w_repeat = tick & r_pressed & w_low & (r_hold >= HW'(REPEAT_TICKS));
    end else begin : g_norep
      assign w_repeat = 1'b0;
    end
  endgenerate
`else
  assign w_repeat = 1'b0;
`endif

  assign press_evt = w_rise | w_repeat;

endmodule

// File: rtl/mult_operand_seq.sv
// -----------------------------------------------------------------------------
// mult_operand_seq
// Lets a user dial in two 4-bit operands with an increment and an advance
// pushbutton, launches an external multiplier, and latches its product.
// Flow: EDIT_A -> EDIT_B -> START (one cycle, mul_start) -> WAIT -> SHOW.
// A missing mul_done for TIMEOUT_TICKS ticks yields product=8'hFF, err=1.
//
// Optional feature: AUTO_REPEAT_EN (macro) enables auto-repeat of the
// increment key inside key_debounce.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_inc_n  in   increment key, active-low, asynchronous
//   key_next_n in   advance key, active-low, asynchronous
//   mul_a      out  operand A
//   mul_b      out  operand B
//   mul_start  out  one-cycle start pulse to the multiplier
//   mul_done   in   multiplier completion strobe
//   mul_p      in   multiplier product, valid with mul_done
//   product    out  latched product
//   err        out  timeout flag
//   state_dbg  out  current state encoding
//   tick       out  one-cycle sampling pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module mult_operand_seq
  import mult_seq_pkg::*;
#(
  parameter int TICK_DIV      = 2500000,
  parameter int TIMEOUT_TICKS = 20,
  parameter int REPEAT_TICKS  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_inc_n,
  input  logic           key_next_n,
  output logic [OPW-1:0] mul_a,
  output logic [OPW-1:0] mul_b,
  output logic           mul_start,
  input  logic           mul_done,
  input  logic [PW-1:0]  mul_p,
  output logic [PW-1:0]  product,
  output logic           err,
  output logic [2:0]     state_dbg,
  output logic           tick
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TOW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [TCW-1:0] r_tick_cnt;
  logic [TOW-1:0] r_to_cnt;
  state_t         r_state;
  logic [OPW-1:0] r_mul_a;
  logic [OPW-1:0] r_mul_b;
  logic [PW-1:0]  r_product;
  logic           r_err;
  logic           r_mul_start;

  logic w_tick;
  logic w_inc;
  logic w_next;

  // Tick is a clock enable derived from the free-running divider.
  assign w_tick = (r_tick_cnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TCW'(1);
    end
  end

  key_debounce #(
    .REPEAT_TICKS(REPEAT_TICKS),
    .REPEAT_EN   (1'b1)
  ) u_key_inc (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_inc_n),
    .tick     (w_tick),
    .press_evt(w_inc)
  );

  key_debounce #(
    .REPEAT_TICKS(REPEAT_TICKS),
    .REPEAT_EN   (1'b0)
  ) u_key_next (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_next_n),
    .tick     (w_tick),
    .press_evt(w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EDIT_A;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_product   <= '0;
      r_err       <= 1'b0;
      r_mul_start <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        // Next takes priority over a coincident increment.
        EDIT_A: begin
          if (w_next) begin
            r_state <= EDIT_B;
          end else if (w_inc) begin
            r_mul_a <= r_mul_a + OPW'(1);
          end
        end
        EDIT_B: begin
          if (w_next) begin
            r_state     <= START;
            r_mul_start <= 1'b1;
          end else if (w_inc) begin
            r_mul_b <= r_mul_b + OPW'(1);
          end
        end
        START: begin
          r_err    <= 1'b0;
          r_to_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            r_product <= mul_p;
            r_state   <= SHOW;
          end else if (w_tick) begin
            if (r_to_cnt == TOW'(TIMEOUT_TICKS - 1)) begin
              r_product <= '1;
              r_err     <= 1'b1;
              r_state   <= SHOW;
            end else begin
              r_to_cnt <= r_to_cnt + TOW'(1);
            end
          end
        end
        SHOW: begin
          if (w_next) begin
            r_state <= EDIT_A;
          end
        end
        default: r_state <= EDIT_A;
      endcase
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_start = r_mul_start;
  assign product   = r_product;
  assign err       = r_err;
  assign state_dbg = r_state;
  assign tick      = w_tick;

endmodule

// File: tb/tb_mult_operand_seq.sv
`timescale 1ns/1ps
module tb_mult_operand_seq;

  localparam int TD = 4;
  localparam int TO = 20;
  localparam int RT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_inc_n;
  logic       key_next_n;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_start;
  logic       mul_done;
  logic [7:0] mul_p;
  logic [7:0] product;
  logic       err;
  logic [2:0] state_dbg;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural multiplier
  int         n_start  = 0;
  logic [3:0] cap_a    = '0;
  logic [3:0] cap_b    = '0;
  int         cd       = 0;
  bit         mdl_never = 1'b0;
  int         mdl_lat   = 7;
  bit         spur_req  = 1'b0;

  int exp_a;
  int exp_b;

  mult_operand_seq #(
    .TICK_DIV     (TD),
    .TIMEOUT_TICKS(TO),
    .REPEAT_TICKS (RT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_inc_n (key_inc_n),
    .key_next_n(key_next_n),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_p     (mul_p),
    .product   (product),
    .err       (err),
    .state_dbg (state_dbg),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    mul_done = 1'b0;
    mul_p    = 8'($urandom);
    if (!rst_n) begin
      cd = 0;
    end else if (spur_req) begin
      spur_req = 1'b0;
      mul_done = 1'b1;
      mul_p    = 8'hA5;
    end else if (mul_start) begin
      n_start++;
      cap_a = mul_a;
      cap_b = mul_b;
      cd    = mdl_never ? 0 : mdl_lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mul_done = 1'b1;
        mul_p    = cap_a * cap_b;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the next cycle in which tick is high.
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (!tick && n < 3 * TD) begin
      @(negedge clk);
      n++;
    end
    if (!tick) check_eq("tick_seen", 32'(tick), 32'd1);
  endtask

  // Hold the chosen key(s) low for low_ticks samples, then release for 3.
  task automatic press(input bit on_inc, input bit on_next, input int low_ticks);
    if (on_inc)  key_inc_n  = 1'b0;
    if (on_next) key_next_n = 1'b0;
    repeat (low_ticks) wait_tick();
    key_inc_n  = 1'b1;
    key_next_n = 1'b1;
    repeat (3) wait_tick();
  endtask

  // Number of inc events produced by one press with low_ticks low samples.
  function automatic int inc_events(input int low_ticks);
    int r;
    r = (low_ticks >= 2) ? 1 : 0;
`ifdef AUTO_REPEAT_EN
    if (low_ticks - 1 - RT > 0) r += low_ticks - 1 - RT;
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    exp_a = 0;
    exp_b = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int n0;
    int na;
    int nb;
    int len;

    rst_n      = 1'b0;
    key_inc_n  = 1'b1;
    key_next_n = 1'b1;
    exp_a      = 0;
    exp_b      = 0;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("rst_a", 32'(mul_a), 32'd0);
    check_eq("rst_b", 32'(mul_b), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_start", 32'(mul_start), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);

    // Tick timing from reset release
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_tick", 32'(n), 32'(TD - 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    check_eq("tick_gap", 32'(n), 32'(TD));

    // Long hold on inc
    press(1'b1, 1'b0, 10);
    exp_a = (exp_a + inc_events(10)) % 16;
    check_eq("hold10_a", 32'(mul_a), 32'(exp_a));

    // Wrap-around and glitch rejection
    do_reset();
    repeat (17) press(1'b1, 1'b0, 2);
    exp_a = (exp_a + 17 * inc_events(2)) % 16;
    check_eq("wrap17_a", 32'(mul_a), 32'(exp_a));
    press(1'b1, 1'b0, 1);
    check_eq("glitch_a", 32'(mul_a), 32'(exp_a));

    // Basic 3 x 5 transaction
    do_reset();
    mdl_lat = 7;
    n0 = n_start;
    repeat (3) press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 2);
    check_eq("editb_state", 32'(state_dbg), 32'd1);
    repeat (5) press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 2);
    exp_a = 3;
    exp_b = 5;
    check_eq("basic_nstart", 32'(n_start - n0), 32'd1);
    check_eq("basic_cap_a", 32'(cap_a), 32'd3);
    check_eq("basic_cap_b", 32'(cap_b), 32'd5);
    check_eq("basic_product", 32'(product), 32'd15);
    check_eq("basic_state", 32'(state_dbg), 32'd4);
    check_eq("basic_err", 32'(err), 32'd0);

    // SHOW ignores inc and stray mul_done, next returns with operands kept
    press(1'b1, 1'b0, 2);
    check_eq("show_inc_a", 32'(mul_a), 32'd3);
    check_eq("show_inc_state", 32'(state_dbg), 32'd4);
    spur_req = 1'b1;
    wait_tick();
    check_eq("spur_done_product", 32'(product), 32'd15);
    press(1'b0, 1'b1, 2);
    check_eq("show_next_state", 32'(state_dbg), 32'd0);
    check_eq("show_next_a", 32'(mul_a), 32'd3);

    // Simultaneous inc and next: next wins
    press(1'b1, 1'b1, 2);
    check_eq("both_state", 32'(state_dbg), 32'd1);
    check_eq("both_a", 32'(mul_a), 32'd3);

    // Timeout
    mdl_never = 1'b1;
    press(1'b0, 1'b1, 2);
    check_eq("to_wait0", 32'(state_dbg), 32'd3);
    repeat (TO - 3) wait_tick();
    check_eq("to_wait19", 32'(state_dbg), 32'd3);
    wait_tick();
    check_eq("to_state", 32'(state_dbg), 32'd4);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_product", 32'(product), 32'hFF);
    press(1'b0, 1'b1, 2);
    mdl_never = 1'b0;

    // Randomized transactions
    for (int it = 0; it < 5; it++) begin
      na = $urandom_range(0, 4);
      nb = $urandom_range(0, 4);
      mdl_lat = $urandom_range(1, 9);
      for (int k = 0; k < na; k++) begin
        len = $urandom_range(1, 3);
        press(1'b1, 1'b0, len);
        exp_a = (exp_a + inc_events(len)) % 16;
      end
      press(1'b0, 1'b1, 2);
      for (int k = 0; k < nb; k++) begin
        len = $urandom_range(1, 3);
        press(1'b1, 1'b0, len);
        exp_b = (exp_b + inc_events(len)) % 16;
      end
      n0 = n_start;
      press(1'b0, 1'b1, 2);
      check_eq("rnd_nstart", 32'(n_start - n0), 32'd1);
      check_eq("rnd_cap_a", 32'(cap_a), 32'(exp_a));
      check_eq("rnd_cap_b", 32'(cap_b), 32'(exp_b));
      check_eq("rnd_product", 32'(product), 32'(exp_a * exp_b));
      check_eq("rnd_err", 32'(err), 32'd0);
      check_eq("rnd_state", 32'(state_dbg), 32'd4);
      press(1'b0, 1'b1, 2);
      check_eq("rnd_back_state", 32'(state_dbg), 32'd0);
    end

    // Reset asserted while waiting on the multiplier
    mdl_never = 1'b1;
    press(1'b0, 1'b1, 2);
    press(1'b0, 1'b1, 2);
    check_eq("mid_wait_state", 32'(state_dbg), 32'd3);
    n0 = n_start;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(state_dbg), 32'd0);
    check_eq("mid_rst_a", 32'(mul_a), 32'd0);
    check_eq("mid_rst_b", 32'(mul_b), 32'd0);
    check_eq("mid_rst_product", 32'(product), 32'd0);
    check_eq("mid_rst_err", 32'(err), 32'd0);
    check_eq("mid_rst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("post_rst_nstart", 32'(n_start - n0), 32'd0);
    check_eq("post_rst_state", 32'(state_dbg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
